// File: rtl/brick_pkg.sv
// Shared brick-health definitions: damage-writer FSM states and the default
// board geometry used by the damage writer, win checker and level loader.
package brick_pkg;

   localparam int DEF_BRICK_COUNT = 64;
   localparam int DEF_INDEX_W     = 6;
   localparam int DEF_HEALTH_W    = 3;

   typedef enum logic [1:0] {
      IDLE,
      READ,
      UPDATE
   } dmg_state_t;

endpackage

// File: rtl/brick_damage_writer.sv
// Read-modify-write of brick health on a hit; one game_write pulse per health
// point actually removed, plus a brick_destroyed pulse when health hits zero.
module brick_damage_writer
   import brick_pkg::*;
#(
   parameter int BRICK_COUNT = DEF_BRICK_COUNT,
   parameter int INDEX_W     = DEF_INDEX_W,
   parameter int HEALTH_W    = DEF_HEALTH_W
) (
   input  logic                clk,
   input  logic                resetn,
   input  logic                hit_valid,
   input  logic [INDEX_W-1:0]  hit_index,
   output logic                hit_ready,
   output logic [INDEX_W-1:0]  mem_addr,
   input  logic [HEALTH_W-1:0] mem_rdata,
   output logic                mem_we,
   output logic [HEALTH_W-1:0] mem_wdata,
   output logic                game_write,
   output logic                brick_destroyed,
   output logic [INDEX_W-1:0]  destroyed_index
);

   dmg_state_t         state_q, state_d;
   logic [INDEX_W-1:0] idx_q, idx_d;
   logic               in_range;

   assign in_range = (32'(hit_index) < 32'(BRICK_COUNT));
   assign mem_addr = idx_q;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= IDLE;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end

   // Outputs are pure decodes of state_q, so an async reset in UPDATE kills the
   // write and the pulses before the edge that would commit them.
   always_comb begin
      state_d         = state_q;
      idx_d           = idx_q;
      hit_ready       = 1'b0;
      mem_we          = 1'b0;
      mem_wdata       = '0;
      game_write      = 1'b0;
      brick_destroyed = 1'b0;
      destroyed_index = '0;
      case (state_q)
         IDLE: begin
            hit_ready = 1'b1;
            // Out-of-range hits are dropped without touching idx_q, so the RAM
            // address bus never sees an invalid slot.
            if (hit_valid && in_range) begin
               idx_d   = hit_index;
               state_d = READ;
            end
         end
         READ: state_d = UPDATE;
         UPDATE: begin
            state_d = IDLE;
            if (mem_rdata != '0) begin
               mem_we     = 1'b1;
               mem_wdata  = mem_rdata - HEALTH_W'(1);
               game_write = 1'b1;
               if (mem_rdata == HEALTH_W'(1)) begin
                  brick_destroyed = 1'b1;
                  destroyed_index = idx_q;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_brick_damage_writer.sv
// Scoreboarded bench for brick_damage_writer with a behavioural 1-cycle RAM.
module tb_brick_damage_writer;
   import brick_pkg::*;

   localparam int BC = 40;
   localparam int IW = 6;
   localparam int HW = 3;

   logic          clk = 1'b0;
   logic          resetn = 1'b0;
   logic          hit_valid = 1'b0;
   logic [IW-1:0] hit_index = '0;
   logic          hit_ready;
   logic [IW-1:0] mem_addr;
   logic [HW-1:0] mem_rdata = '0;
   logic          mem_we;
   logic [HW-1:0] mem_wdata;
   logic          game_write;
   logic          brick_destroyed;
   logic [IW-1:0] destroyed_index;

   brick_damage_writer #(.BRICK_COUNT(BC), .INDEX_W(IW), .HEALTH_W(HW)) dut (
      .clk(clk), .resetn(resetn), .hit_valid(hit_valid), .hit_index(hit_index),
      .hit_ready(hit_ready), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
      .mem_we(mem_we), .mem_wdata(mem_wdata), .game_write(game_write),
      .brick_destroyed(brick_destroyed), .destroyed_index(destroyed_index)
   );

   always #5 clk = ~clk;

   // Health RAM with a bench-side load port
   logic [HW-1:0] ram [64];
   logic [HW-1:0] shadow [64];
   logic          ram_clr = 1'b0;
   logic          ld_en = 1'b0;
   logic [IW-1:0] ld_addr = '0;
   logic [HW-1:0] ld_data = '0;

   always @(posedge clk) begin
      mem_rdata <= ram[mem_addr];
      if (ram_clr) begin
         for (int i = 0; i < 64; i++) ram[i] <= '0;
      end else if (ld_en) ram[ld_addr] <= ld_data;
      else if (mem_we) ram[mem_addr] <= mem_wdata;
   end

   typedef struct {
      logic [IW-1:0] idx;
      logic          we;
      logic [HW-1:0] wdata;
      logic          dest;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   int   checks = 0;
   int   failures = 0;
   int   gw_cnt = 0;
   int   bd_cnt = 0;
   logic [1:0] acc_sh = '0;

   // acc_sh[1] marks the UPDATE cycle of an in-range accepted hit
   always @(posedge clk) begin
      if (!resetn) acc_sh <= '0;
      else acc_sh <= {acc_sh[0], hit_valid && hit_ready && (int'(hit_index) < BC)};
   end

   always @(negedge clk) begin
      if (!resetn) sb.delete();
      else begin
         if (game_write) gw_cnt++;
         if (brick_destroyed) bd_cnt++;
         if (acc_sh[1]) begin
            checks++;
            if (sb.size() == 0) begin
               failures++;
               $display("FAIL sb_underflow: DUT update with no expected entry");
            end else begin
               e = sb.pop_front();
               if (mem_we !== e.we || game_write !== e.we || brick_destroyed !== e.dest ||
                   mem_addr !== e.idx || (e.we && mem_wdata !== e.wdata) ||
                   (e.dest && destroyed_index !== e.idx)) begin
                  failures++;
                  $display("FAIL update idx=%0d: got we=%b gw=%b bd=%b addr=%0d wdata=%0d didx=%0d required we=%b gw=%b bd=%b addr=%0d wdata=%0d didx=%0d",
                           e.idx, mem_we, game_write, brick_destroyed, mem_addr, mem_wdata,
                           destroyed_index, e.we, e.we, e.dest, e.idx, e.wdata, e.idx);
               end
            end
         end else begin
            checks++;
            if (mem_we !== 1'b0 || game_write !== 1'b0 || brick_destroyed !== 1'b0) begin
               failures++;
               $display("FAIL quiet: got we=%b gw=%b bd=%b required 0 0 0",
                        mem_we, game_write, brick_destroyed);
            end
         end
      end
   end

   task automatic set_brick(input int i, input logic [HW-1:0] h);
      @(negedge clk);
      ld_en = 1'b1; ld_addr = IW'(i); ld_data = h;
      @(negedge clk);
      ld_en = 1'b0;
      shadow[i] = h;
   endtask

   // Holds hit_valid until n handshakes have been seen; returns first/last accept edge times
   task automatic send_hits(input logic [IW-1:0] idx, input int n, output time t_first, output time t_last);
      int got;
      int guard;
      exp_t x;
      logic [HW-1:0] h;
      got = 0; guard = 0; t_first = 0; t_last = 0;
      @(negedge clk);
      hit_index = idx; hit_valid = 1'b1;
      while (got < n) begin
         if (guard >= 40) begin
            checks++; failures++;
            $display("FAIL accept_timeout idx=%0d: got %0d accepts required %0d", idx, got, n);
            break;
         end
         guard++;
         if (hit_ready) begin
            got++;
            if (int'(idx) < BC) begin
               h = shadow[idx];
               x.idx = idx; x.we = (h != '0); x.wdata = h - HW'(1); x.dest = (h == HW'(1));
               if (h != '0) shadow[idx] = h - HW'(1);
               sb.push_back(x);
            end
            @(posedge clk);
            if (got == 1) t_first = $time;
            t_last = $time;
            if (got < n) @(negedge clk);
         end else @(negedge clk);
      end
      #1 hit_valid = 1'b0;
   endtask

   task automatic check_counts(input string name, input int g0, input int b0, input int gexp, input int bexp);
      checks++;
      if (gw_cnt - g0 != gexp || bd_cnt - b0 != bexp) begin
         failures++;
         $display("FAIL %s pulses: got gw=%0d bd=%0d required gw=%0d bd=%0d",
                  name, gw_cnt - g0, bd_cnt - b0, gexp, bexp);
      end
   endtask

   task automatic test_reset();
      resetn = 1'b0; ram_clr = 1'b1; hit_valid = 1'b1; hit_index = 6'd3;
      #2;
      checks++;
      if (hit_ready !== 1'b1 || mem_we !== 1'b0 || game_write !== 1'b0 || brick_destroyed !== 1'b0 ||
          mem_addr !== '0 || mem_wdata !== '0 || destroyed_index !== '0) begin
         failures++;
         $display("FAIL reset_values: rdy=%b we=%b gw=%b bd=%b addr=%0d wdata=%0d didx=%0d required 1 0 0 0 0 0 0",
                  hit_ready, mem_we, game_write, brick_destroyed, mem_addr, mem_wdata, destroyed_index);
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      ram_clr = 1'b0; hit_valid = 1'b0;
      for (int i = 0; i < 64; i++) shadow[i] = '0;
      resetn = 1'b1;
      @(negedge clk);
      checks++;
      if (mem_addr !== '0 || hit_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_no_handshake: addr=%0d rdy=%b required 0 1", mem_addr, hit_ready);
      end
   endtask

   task automatic test_single();
      time ta, tz;
      int g0, b0;
      set_brick(5, 3'd3);
      g0 = gw_cnt; b0 = bd_cnt;
      send_hits(6'd5, 1, ta, tz);
      @(negedge clk);
      checks++;
      if (hit_ready !== 1'b0) begin failures++; $display("FAIL single_busy: rdy=%b required 0", hit_ready); end
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (hit_ready !== 1'b1) begin failures++; $display("FAIL single_ready_t3: rdy=%b required 1", hit_ready); end
      check_counts("single", g0, b0, 1, 0);
      checks++;
      if (ram[5] !== 3'd2) begin failures++; $display("FAIL single_ram: got %0d required 2", ram[5]); end
   endtask

   task automatic test_destroy();
      time ta, tz;
      int g0, b0;
      set_brick(5, 3'd1);
      g0 = gw_cnt; b0 = bd_cnt;
      send_hits(6'd5, 1, ta, tz);
      repeat (3) @(negedge clk);
      check_counts("destroy", g0, b0, 1, 1);
      checks++;
      if (ram[5] !== 3'd0) begin failures++; $display("FAIL destroy_ram: got %0d required 0", ram[5]); end
   endtask

   task automatic test_dead();
      time ta, tz;
      int g0, b0;
      set_brick(7, 3'd0);
      g0 = gw_cnt; b0 = bd_cnt;
      send_hits(6'd7, 1, ta, tz);
      repeat (3) @(negedge clk);
      checks++;
      if (hit_ready !== 1'b1) begin failures++; $display("FAIL dead_ready_t3: rdy=%b required 1", hit_ready); end
      check_counts("dead", g0, b0, 0, 0);
      checks++;
      if (ram[7] !== 3'd0) begin failures++; $display("FAIL dead_ram: got %0d required 0", ram[7]); end
   endtask

   task automatic test_range();
      time ta, tz;
      int g0, b0;
      logic [IW-1:0] bad [2];
      bad[0] = 6'd50; bad[1] = 6'd40;
      set_brick(39, 3'd1);
      g0 = gw_cnt; b0 = bd_cnt;
      for (int k = 0; k < 2; k++) begin
         send_hits(bad[k], 1, ta, tz);
         @(negedge clk);
         checks++;
         if (hit_ready !== 1'b1) begin
            failures++;
            $display("FAIL range_drop idx=%0d: rdy=%b required 1", bad[k], hit_ready);
         end
      end
      repeat (2) @(negedge clk);
      check_counts("range_drop", g0, b0, 0, 0);
      send_hits(6'd39, 1, ta, tz);
      repeat (3) @(negedge clk);
      check_counts("range_edge", g0, b0, 1, 1);
      checks++;
      if (ram[39] !== 3'd0) begin failures++; $display("FAIL range_edge_ram: got %0d required 0", ram[39]); end
   endtask

   task automatic test_back_to_back();
      time ta, tz;
      int g0, b0;
      set_brick(2, 3'd2);
      g0 = gw_cnt; b0 = bd_cnt;
      send_hits(6'd2, 2, ta, tz);
      repeat (3) @(negedge clk);
      checks++;
      if (tz - ta != 30) begin failures++; $display("FAIL b2b_spacing: got %0t required 30", tz - ta); end
      check_counts("b2b", g0, b0, 2, 1);
      checks++;
      if (ram[2] !== 3'd0) begin failures++; $display("FAIL b2b_ram: got %0d required 0", ram[2]); end
   endtask

   task automatic test_reset_in_update();
      time ta, tz;
      int g0, b0;
      set_brick(9, 3'd2);
      send_hits(6'd9, 1, ta, tz);
      @(negedge clk);
      @(negedge clk);
      #1;
      checks++;
      if (mem_we !== 1'b1 || game_write !== 1'b1) begin
         failures++;
         $display("FAIL rst_upd_pre: we=%b gw=%b required 1 1", mem_we, game_write);
      end
      resetn = 1'b0;
      #1;
      checks++;
      if (mem_we !== 1'b0 || game_write !== 1'b0 || brick_destroyed !== 1'b0 || hit_ready !== 1'b1) begin
         failures++;
         $display("FAIL rst_upd_drop: we=%b gw=%b bd=%b rdy=%b required 0 0 0 1",
                  mem_we, game_write, brick_destroyed, hit_ready);
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      resetn = 1'b1;
      shadow[9] = 3'd2;
      @(negedge clk);
      checks++;
      if (ram[9] !== 3'd2 || hit_ready !== 1'b1) begin
         failures++;
         $display("FAIL rst_upd_after: ram=%0d rdy=%b required 2 1", ram[9], hit_ready);
      end
      g0 = gw_cnt; b0 = bd_cnt;
      send_hits(6'd9, 1, ta, tz);
      repeat (3) @(negedge clk);
      check_counts("rst_upd_resume", g0, b0, 1, 0);
      checks++;
      if (ram[9] !== 3'd1) begin failures++; $display("FAIL rst_upd_resume_ram: got %0d required 1", ram[9]); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_destroy();
      test_dead();
      test_range();
      test_back_to_back();
      test_reset_in_update();
      repeat (2) @(negedge clk);
      checks++;
      if (sb.size() != 0) begin failures++; $display("FAIL sb_leftover: got %0d entries required 0", sb.size()); end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
